divider_issue_ctrl: RTL
=======================

// Module: divider_issue_ctrl
// PURPOSE
// - Issue/retire stage between the AFU command logic and the fixed-latency pipelined divider.
// - Accepts operand pairs on a valid/ready port and drives the divider's a/b/reset inputs.
// - Tags in-flight operations with a valid shift register, captures each result on its exact
//   retire cycle into a result FIFO, and returns results in order on a valid/ready port.
// - Credit-based admission means no result is ever dropped.
// PARAMETERS
// - DATA_LEN        32  operand/result width; must match the divider instance
// - PIPELINE_STATE  10  divider latency in cycles, operand-in to result-out, >=1
// - RES_DEPTH       16  result FIFO entries, power of 2, >= PIPELINE_STATE+1
// PORTS
// - clk            in   1         clock
// - reset_n        in   1         synchronous, active-low reset
// - flush          in   1         abort all queued and in-flight work
// - in_valid       in   1         operand pair valid
// - in_ready       out  1         operand pair accepted when in_valid & in_ready
// - in_a           in   DATA_LEN  dividend
// - in_b           in   DATA_LEN  divisor
// - div_reset      out  1         to divider reset (active-high)
// - div_a          out  DATA_LEN  to divider a, registered
// - div_b          out  DATA_LEN  to divider b, registered
// - div_result     in   DATA_LEN  from divider result
// - out_valid      out  1         result available
// - out_ready      in   1         result consumed when out_valid & out_ready
// - out_data       out  DATA_LEN  quotient
// - out_dz         out  1         divide-by-zero flag (see CONFIGURATION)
// - stat_issued    out  32        accepted operations, wraps mod 2^32
// - stat_retired   out  32        results consumed, wraps mod 2^32
// BEHAVIOUR
// - Interface: one clock, clk. Reset reset_n is synchronous and active-low.
// - Reset (reset_n=0 at a clk edge):
//   - FSM=RUN; FIFO empty; tag shift register cleared; stats=0.
//   - div_a=div_b=0; div_reset=1 while reset_n=0.
//   - Outputs: in_ready=0, out_valid=0, out_data=0, out_dz=0.
// - FSM states:
//   - RUN: normal operation.
//   - FLUSH: exactly 1 cycle, div_reset=1.
//   - RECOVER: PIPELINE_STATE cycles, in_ready=0, then back to RUN.
//   - Transitions: flush in any state -> FLUSH; RECOVER counter reaching 0 -> RUN.
// - Admission: in_ready = (state==RUN) & (fifo_count + inflight < RES_DEPTH).
//   - Both terms are registered counts.
// - Issue: an accept at edge N loads div_a/div_b=in_a/in_b and sets tag[0] at edge N.
//   - Cycles with no accept load div_a=div_b=0.
// - Retire: the result of the op issued at edge N is sampled from div_result at edge
//   N+PIPELINE_STATE and written to the FIFO when tag[PIPELINE_STATE-1]=1.
//   - Untagged cycles write nothing.
// - inflight = popcount of the tag register, kept as an up/down counter.
//   - Simultaneous issue and retire leaves inflight unchanged.
// - FIFO:
//   - Push and pop in the same cycle is legal, including at full or empty.
//   - There is no bypass: the earliest out_valid is 1 cycle after the retire edge.
//   - Pointers wrap modulo RES_DEPTH.
//   - Total latency from accept to out_valid is PIPELINE_STATE+1 cycles.
// - out_data/out_dz are driven from the FIFO head and hold stable while out_valid & !out_ready.
// - Stats: stat_issued increments on accept; stat_retired increments on pop.
// - flush:
//   - Clears the FIFO and tags and sets inflight=0; the stats are kept.
//   - out_valid falls on the next edge.
//   - A simultaneous accept or pop is ignored and not counted.
//   - flush asserted during RECOVER restarts the FLUSH/RECOVER sequence.
// - reset_n=0 mid-operation has the same effect as reset, and the stats are cleared.
// CONFIGURATION
// - Macro DIVIDER_DIVZERO_DETECT_EN:
//   - Defined: (in_b==0) travels in a sideband shift register alongside the tag.
//     On retire, that entry stores out_data={DATA_LEN{1'b1}} and out_dz=1,
//     and div_result is ignored.
//   - Undefined: no sideband register; out_dz is tied to 0; div_result is stored unmodified.
// TESTING
// - Single op a=100, b=7, out_ready=1 -> out_valid 11 cycles after the accept,
//   out_data=14, stat_issued=stat_retired=1.
// - Back-to-back burst of 16 ops ((1000,i+1) for i=0..15), out_ready=0:
//   - in_ready drops after the 16th accept and out_valid holds.
//   - Raising out_ready yields quotients 1000/(i+1) in order; in_ready returns 1 cycle
//     after the first pop.
// - Random out_ready (50%) with a continuous 200-op stream -> no loss or reorder;
//   fifo_count+inflight never exceeds 16.
// - flush 4 cycles after 5 accepts -> div_reset=1 for 1 cycle, in_ready=0 for 11 cycles,
//   no out_valid for the flushed ops; the next op a=9, b=3 returns 3.
// - Macro defined, a=5, b=0 -> out_data=32'hFFFFFFFF, out_dz=1.
//   - Macro undefined: out_dz=0 and out_data=divider output.
// - reset_n low for 1 cycle mid-burst -> all outputs are at their reset values on the next
//   cycle and the stats read 0.

Source files
------------

// File: rtl/divider_issue_ctrl_if.sv
// Operand-issue and result-return valid/ready handshakes of divider_issue_ctrl.
interface divider_issue_ctrl_if #(
    parameter int DATA_LEN = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_LEN-1:0] in_a;
    logic [DATA_LEN-1:0] in_b;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] out_data;
    logic                out_dz;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_dz
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_dz
    );
endinterface

// File: rtl/divider_issue_ctrl.sv
// Issue/retire controller for a fixed-latency pipelined divider with credit-gated result FIFO.
// Optional divide-by-zero sideband: define DIVIDER_DIVZERO_DETECT_EN.
module divider_issue_ctrl #(
    parameter int DATA_LEN       = 32,
    parameter int PIPELINE_STATE = 10,
    parameter int RES_DEPTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    divider_issue_ctrl_if.slave  bus,
    output logic                 div_reset,
    output logic [DATA_LEN-1:0]  div_a,
    output logic [DATA_LEN-1:0]  div_b,
    input  logic [DATA_LEN-1:0]  div_result,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_retired
);

    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int CNT_W = $clog2(RES_DEPTH + 1);
    localparam int INF_W = $clog2(PIPELINE_STATE + 1);
`ifdef DIVIDER_DIVZERO_DETECT_EN
    localparam int MEM_W = DATA_LEN + 1;
`else
    localparam int MEM_W = DATA_LEN;
`endif
    localparam logic [INF_W-1:0] RECOVER_LOAD = INF_W'(PIPELINE_STATE - 1);

    // state      | meaning
    // ST_RUN     | normal issue/retire
    // ST_FLUSH   | one cycle, divider held in reset
    // ST_RECOVER | PIPELINE_STATE cycles of no issue while the divider drains
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [INF_W-1:0]          recover_cnt;
    logic [INF_W-1:0]          recover_cnt_next;
    logic                      run;

    logic [PIPELINE_STATE-1:0] tag;
    logic [PIPELINE_STATE-1:0] tag_next;
    logic [INF_W-1:0]          inflight;
    logic [CNT_W-1:0]          fifo_count;
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [MEM_W-1:0]          mem [RES_DEPTH];
    logic [MEM_W-1:0]          wr_word;
    logic [MEM_W-1:0]          head;

    logic                      credit_ok;
    logic                      accept;
    logic                      pop;
    logic                      retire;
    logic                      push;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_RUN;
            recover_cnt <= '0;
        end else begin
            state       <= state_next;
            recover_cnt <= recover_cnt_next;
        end
    end

    always_comb begin
        state_next       = state;
        recover_cnt_next = recover_cnt;
        run              = 1'b0;
        div_reset        = !reset_n;
        case (state)
            ST_RUN: begin
                run = 1'b1;
            end
            ST_FLUSH: begin
                div_reset        = 1'b1;
                state_next       = ST_RECOVER;
                recover_cnt_next = RECOVER_LOAD;
            end
            ST_RECOVER: begin
                if (recover_cnt == '0) begin
                    state_next = ST_RUN;
                end else begin
                    recover_cnt_next = recover_cnt - INF_W'(1);
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
        if (flush) begin
            state_next = ST_FLUSH;
        end
    end

    // Every in-flight tag owns a FIFO slot, so a retiring result always finds space.
    assign credit_ok     = (32'(fifo_count) + 32'(inflight)) < 32'(RES_DEPTH);
    assign bus.in_ready  = reset_n & run & credit_ok;
    assign bus.out_valid = (fifo_count != '0);

    assign accept = bus.in_valid & bus.in_ready & ~flush;
    assign pop    = bus.out_valid & bus.out_ready & ~flush;
    assign retire = tag[PIPELINE_STATE-1];
    assign push   = retire & ~flush;

    always_comb begin
        tag_next    = tag << 1;
        tag_next[0] = accept;
    end

    assign head = mem[rd_ptr];

`ifdef DIVIDER_DIVZERO_DETECT_EN
    logic [PIPELINE_STATE-1:0] dz_tag;
    logic [PIPELINE_STATE-1:0] dz_tag_next;

    always_comb begin
        dz_tag_next    = dz_tag << 1;
        dz_tag_next[0] = accept & (bus.in_b == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            dz_tag <= '0;
        end else begin
            dz_tag <= dz_tag_next;
        end
    end

    assign wr_word      = dz_tag[PIPELINE_STATE-1] ? {1'b1, {DATA_LEN{1'b1}}} : {1'b0, div_result};
    assign bus.out_data = bus.out_valid ? head[DATA_LEN-1:0] : '0;
    assign bus.out_dz   = bus.out_valid & head[DATA_LEN];
`else
    assign wr_word      = div_result;
    assign bus.out_data = bus.out_valid ? head : '0;
    assign bus.out_dz   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag          <= '0;
            inflight     <= '0;
            fifo_count   <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            div_a        <= '0;
            div_b        <= '0;
            stat_issued  <= '0;
            stat_retired <= '0;
        end else begin
            div_a <= accept ? bus.in_a : '0;
            div_b <= accept ? bus.in_b : '0;
            if (flush) begin
                tag        <= '0;
                inflight   <= '0;
                fifo_count <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
            end else begin
                tag <= tag_next;
                case ({accept, retire})
                    2'b10:   inflight <= inflight + INF_W'(1);
                    2'b01:   inflight <= inflight - INF_W'(1);
                    default: inflight <= inflight;
                endcase
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                    2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                    default: fifo_count <= fifo_count;
                endcase
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
            if (accept) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (pop) begin
                stat_retired <= stat_retired + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            mem[wr_ptr] <= wr_word;
        end
    end

endmodule
